axil_slave_regfile: RTL and testbench

AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

---
 rtl/axil_slave_regfile.sv | 167 ++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte-strobed writes.
// Latency: BVALID one cycle after the second AW/W handshake, RVALID one cycle after AR; B/R stall indefinitely on BREADY/RREADY low.
module axil_slave_regfile #(
    parameter int unsigned NUM_REGS  = 4,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t           w_state, w_state_nxt;
    r_state_t           r_state, r_state_nxt;
    logic               rdy_en;
    logic [31:0]        regs [NUM_REGS];
    logic [31:0]        aw_addr_q, w_data_q, rdata_q;
    logic [3:0]         w_strb_q;
    logic [1:0]         bresp_q, rresp_q;

    logic               aw_hs, w_hs, ar_hs, wr_commit;
    logic [31:0]        wr_addr, wr_data;
    logic [3:0]         wr_strb;
    logic               wr_ok, rd_ok;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               unused_ok;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign ar_hs = ARVALID & ARREADY;

    // Whichever half arrived first was latched; the other comes straight off the bus.
    assign wr_addr   = (w_state == W_HAVE_A) ? aw_addr_q : AWADDR;
    assign wr_data   = (w_state == W_HAVE_D) ? w_data_q  : WDATA;
    assign wr_strb   = (w_state == W_HAVE_D) ? w_strb_q  : WSTRB;
    assign wr_ok     = ~|wr_addr[31:IDX_W+2];
    assign wr_idx    = wr_addr[IDX_W+1:2];
    assign rd_ok     = ~|ARADDR[31:IDX_W+2];
    assign rd_idx    = ARADDR[IDX_W+1:2];
    assign unused_ok = ^{AWPROT, ARPROT, wr_addr[1:0], ARADDR[1:0]};

    assign wr_commit = ((w_state == W_IDLE)   & aw_hs & w_hs) |
                       ((w_state == W_HAVE_A) & w_hs) |
                       ((w_state == W_HAVE_D) & aw_hs);

    // Keeps all READYs low during reset and for the release cycle itself.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdy_en  <= 1'b0;
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            rdy_en  <= 1'b1;
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = rdy_en;
                WREADY  = rdy_en;
                if (aw_hs && w_hs) w_state_nxt = W_RESP;
                else if (aw_hs)    w_state_nxt = W_HAVE_A;
                else if (w_hs)     w_state_nxt = W_HAVE_D;
            end
            W_HAVE_A: begin
                WREADY = rdy_en;
                if (w_hs) w_state_nxt = W_RESP;
            end
            W_HAVE_D: begin
                AWREADY = rdy_en;
                if (aw_hs) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = rdy_en;
                if (ar_hs) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= 2'b00;
        end else begin
            if (aw_hs)     aw_addr_q <= AWADDR;
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (wr_commit) bresp_q <= wr_ok ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (wr_commit && wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Read capture sees pre-write contents when a write commits on the same edge.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else if (ar_hs) begin
            rdata_q <= rd_ok ? regs[rd_idx] : 32'h0;
            rresp_q <= rd_ok ? 2'b00 : 2'b10;
        end
    end

    assign BRESP = bresp_q;
    assign RDATA = rdata_q;
    assign RRESP = rresp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed plus randomized checks of axil_slave_regfile against an array-based register model.
module tb_axil_slave_regfile;
    localparam int NREGS = 4;

    logic        ACLK, ARESETn;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mregs [NREGS];

    axil_slave_regfile #(.NUM_REGS(NREGS), .RESET_VAL(32'h0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a / 4) < NREGS;
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 4) == 0)
            return 32'(NREGS * 4) + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
        return 32'($urandom_range(0, NREGS - 1) * 4 + $urandom_range(0, 3));
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int  cyc;
        bit  aw_done, w_done, aw_fire, w_fire;
        logic [1:0] exp_resp;
        exp_resp = 2'b10;
        if (in_range(addr)) begin
            exp_resp = 2'b00;
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            @(negedge ACLK);
            check("b_not_early", BVALID, 0);
            AWVALID = !aw_done && cyc >= aw_dly; AWADDR = addr; AWPROT = 3'($urandom);
            WVALID  = !w_done && cyc >= w_dly;   WDATA  = data; WSTRB  = strb;
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK);
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        if (!(aw_done && w_done)) check("write_handshake_timeout", 0, 1);
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        check("bvalid_next_cycle", BVALID, 1);
        check("bresp", BRESP, exp_resp);
        for (int i = 0; i < b_dly; i++) begin
            check("b_stall_bvalid", BVALID, 1);
            check("b_stall_bresp", BRESP, exp_resp);
            check("b_stall_awready", AWREADY, 0);
            check("b_stall_wready", WREADY, 0);
            @(negedge ACLK);
        end
        BREADY = 1;
        check("bvalid_at_accept", BVALID, 1);
        @(negedge ACLK);
        BREADY = 0;
        check("bvalid_cleared", BVALID, 0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        int cyc;
        bit fired;
        logic [31:0] exp_dat;
        logic [1:0]  exp_resp;
        exp_dat  = in_range(addr) ? mregs[addr / 4] : 32'h0;
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        fired = 0; cyc = 0;
        while (!fired && cyc < 64) begin
            @(negedge ACLK);
            ARVALID = 1; ARADDR = addr; ARPROT = 3'($urandom);
            fired = ARREADY;
            cyc++;
        end
        if (!fired) check("read_handshake_timeout", 0, 1);
        @(negedge ACLK);
        ARVALID = 0;
        check("rvalid_next_cycle", RVALID, 1);
        check("rdata", RDATA, exp_dat);
        check("rresp", RRESP, exp_resp);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            check("r_stall_rvalid", RVALID, 1);
            check("r_stall_rdata", RDATA, exp_dat);
            check("r_stall_arready", ARREADY, 0);
        end
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        check("rvalid_cleared", RVALID, 0);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            check(tag, {31'b0, in_range(32'(i * 4))}, 1);
            do_read(32'(i * 4), 0);
        end
    endtask

    initial begin
        int aw_cnt, b_cnt, ar_cnt, r_cnt;
        logic [31:0] d;
        ARESETn = 0; AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0;
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;

        // Reset state
        #1;
        check("rst_awready", AWREADY, 0); check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0); check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);   check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);     check("rst_rdata", RDATA, 0);
        repeat (3) @(negedge ACLK);
        ARESETn = 1;
        @(posedge ACLK); #1;
        check("rel_awready", AWREADY, 1); check("rel_wready", WREADY, 1);
        check("rel_arready", ARREADY, 1);

        // AW+W same cycle
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(32'h4, 0);

        // W three cycles ahead of AW, partial strobe
        do_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0);
        check("strb_model", mregs[2], 32'h00220044);
        do_read(32'h8, 0);

        // Zero strobe leaves the register unchanged
        do_write(32'h4, 32'h12345678, 4'h0, 1, 0, 0);
        do_read(32'h4, 0);

        // Out of range
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 2, 0);
        do_read(32'h40, 0);
        check_all_regs("oor_regs_intact");

        // Response stalls
        do_write(32'hC, 32'hA5A5_5A5A, 4'hF, 0, 0, 5);
        do_read(32'hC, 5);

        // Same-edge read and write of register 0
        do_write(32'h0, 32'h1, 4'hF, 0, 0, 0);
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 0; WVALID = 1; WDATA = 32'h2; WSTRB = 4'hF;
        ARVALID = 1; ARADDR = 0;
        check("same_edge_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        mregs[0] = 32'h2;
        check("same_edge_rvalid", RVALID, 1);
        check("same_edge_rdata_old", RDATA, 32'h1);
        check("same_edge_bvalid", BVALID, 1);
        BREADY = 1; RREADY = 1;
        @(negedge ACLK);
        BREADY = 0; RREADY = 0;
        do_read(32'h0, 0);

        // Back-to-back throughput
        d = $urandom;
        aw_cnt = 0; b_cnt = 0;
        @(negedge ACLK);
        AWVALID = 1; WVALID = 1; BREADY = 1; AWADDR = 32'h4; WDATA = d; WSTRB = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge ACLK);
            if (AWVALID && AWREADY) aw_cnt++;
            if (BVALID && BREADY) b_cnt++;
        end
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; BREADY = 0;
        mregs[1] = d;
        check("wr_throughput_aw", aw_cnt, 4);
        check("wr_throughput_b", b_cnt, 4);
        ar_cnt = 0; r_cnt = 0;
        ARVALID = 1; RREADY = 1; ARADDR = 32'h4;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge ACLK);
            if (ARVALID && ARREADY) ar_cnt++;
            if (RVALID && RREADY) begin
                r_cnt++;
                check("rd_throughput_data", RDATA, d);
            end
        end
        @(negedge ACLK);
        ARVALID = 0; RREADY = 0;
        check("rd_throughput_ar", ar_cnt, 4);
        check("rd_throughput_r", r_cnt, 4);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 3));
        end
        check_all_regs("random_final");

        // Reset while holding a write address
        @(negedge ACLK);
        AWVALID = 1; AWADDR = 32'hC;
        @(negedge ACLK);
        AWVALID = 0;
        check("have_a_awready", AWREADY, 0);
        check("have_a_wready", WREADY, 1);
        ARESETn = 0;
        #1;
        for (int i = 0; i < NREGS; i++) mregs[i] = 32'h0;
        check("mid_rst_awready", AWREADY, 0); check("mid_rst_wready", WREADY, 0);
        check("mid_rst_arready", ARREADY, 0); check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rvalid", RVALID, 0);   check("mid_rst_bresp", BRESP, 0);
        check("mid_rst_rresp", RRESP, 0);     check("mid_rst_rdata", RDATA, 0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1;
        @(posedge ACLK); #1;
        check("rel2_awready", AWREADY, 1); check("rel2_wready", WREADY, 1);
        check("rel2_arready", ARREADY, 1); check("rel2_bvalid", BVALID, 0);
        check_all_regs("post_reset_regs");
        do_write(32'h8, 32'h0BAD_F00D, 4'hC, 2, 0, 1);
        do_read(32'h8, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
